// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- IF stage of the 5-stage MIPS pipeline.
//
// Owns the PC, issues one outstanding instruction-memory request at a time
// over a valid/ready handshake, picks the next PC (sequential, branch, jump)
// and drives the IF/ID pipeline register consumed by instr_decode.
//
// Ports
//   clk              in   clock, all state updates on the rising edge
//   reset            in   asynchronous, active-high reset
//   stall_if         in   hazard stall: freezes PC and IF/ID
//   pc_src           in   branch taken (from decode)
//   jump             in   jump (from decode), wins over pc_src
//   pc_branch[31:0]  in   branch target
//   pc_jump[31:0]    in   jump target
//   imem_ready       in   imem_rdata is valid for imem_addr this cycle
//   imem_rdata[31:0] in   fetched instruction word
//   imem_req         out  fetch request (address stable until ready)
//   imem_addr[31:0]  out  fetch address, always the PC
//   if_id_instr      out  IF/ID instruction, 0 = bubble
//   if_id_pc_plus_4  out  IF/ID PC+4 of that instruction
//   if_id_valid      out  IF/ID holds a real instruction
//   fetch_busy       out  request outstanding and memory not ready
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        pc_src,
  input  logic        jump,
  input  logic [31:0] pc_branch,
  input  logic [31:0] pc_jump,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus_4,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  // S_FETCH : request outstanding for the PC
  // S_HOLD  : word captured during a stall, waiting in the buffer, no request
  // S_SQUASH: finishing a fetch that a redirect made wrong-path
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus_4;

  // A redirect seen during a stall is ignored; decode re-presents it later.
  assign redirect  = (pc_src | jump) & ~stall_if;
  assign target    = jump ? pc_jump : pc_branch;
  assign pc_plus_4 = pc_q + 32'd4;

  assign imem_req        = ~reset & (state_q != S_HOLD);
  assign imem_addr       = pc_q;
  assign fetch_busy      = imem_req & ~imem_ready;
  assign if_id_instr     = instr_q;
  assign if_id_pc_plus_4 = pc4_q;
  assign if_id_valid     = valid_q;

  always_comb begin
    // NOTE: every next-state signal gets its "hold" value first so that no
    // path through the case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    redir_pc_d = redir_pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;

    unique case (state_q)
      S_FETCH: begin
        if (stall_if) begin
          // Park the returning word; IF/ID must not move while stalled.
          if (imem_ready) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end
        end else begin
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          if (redirect) begin
            if (imem_ready) begin
              pc_d = target;
            end else begin
              // Address must stay put until the memory answers, so the
              // target waits in redir_pc.
              redir_pc_d = target;
              state_d    = S_SQUASH;
            end
          end else if (imem_ready) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus_4;
            valid_d = 1'b1;
            pc_d    = pc_plus_4;
          end
        end
      end

      S_HOLD: begin
        if (!stall_if) begin
          state_d = S_FETCH;
          if (redirect) begin
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            pc_d    = target;
          end else begin
            instr_d = buf_q;
            pc4_d   = pc_plus_4;
            valid_d = 1'b1;
            pc_d    = pc_plus_4;
          end
        end
      end

      S_SQUASH: begin
        if (!stall_if) begin
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end
        if (redirect) begin
          redir_pc_d = target;
        end
        if (imem_ready) begin
          // A redirect in the completing cycle is newer than redir_pc.
          pc_d    = redirect ? target : redir_pc_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of evaluation order between processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      buf_q      <= 32'd0;
      redir_pc_q <= 32'd0;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      redir_pc_q <= redir_pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end

endmodule
